// File: rtl/pushit_q_if.sv
// Byte-wide stream from the record packer into the downstream byte FIFO.
// A byte moves on a clock edge where write is high and busy is low.
interface pushit_q_if;
    logic [7:0] data;
    logic       write;
    logic       busy;

    modport master (output data, output write, input busy);
    modport slave  (input data, input write, output busy);
endinterface

// File: rtl/pushit_q.sv
// Trigger/cycle record packer: queues trigger records, holds one cycle record and
// serialises each as header, LSB-first payload chunks and an optional XOR checksum.
module pushit_q #(
    parameter int unsigned NUMW  = 18,
    parameter int unsigned TIMEW = 36,
    parameter int unsigned CHUNK = 6,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CKSUM = 1,
    parameter int unsigned LOSTW = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   trigready,
    input  logic                   cycleready,
    input  logic [NUMW-1:0]        trignum,
    input  logic [TIMEW-1:0]       timenum,
    input  logic [NUMW-1:0]        cyclenum,
    pushit_q_if.master             fifo,
    output logic [LOSTW-1:0]       lostcnt,
    output logic [$clog2(DEPTH):0] qlevel
);
    localparam int unsigned NCH_N = (NUMW + CHUNK - 1) / CHUNK;
    localparam int unsigned NCH_M = (TIMEW + CHUNK - 1) / CHUNK;
    localparam int unsigned NCH_T = NCH_N + NCH_M;
    localparam int unsigned NCH_C = NCH_N;
    localparam int unsigned PADN  = NCH_N * CHUNK;
    localparam int unsigned PADM  = NCH_M * CHUNK;
    localparam int unsigned SHW   = PADN + PADM;
    localparam int unsigned RECW  = NUMW + TIMEW;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = $clog2(NCH_T + 1);

    typedef enum logic [1:0] {StIdle, StHdr, StPay, StCk} state_e;

    // Serialiser state
    state_e           state_q;
    logic [7:0]       data_q;
    logic             write_q;
    logic [SHW-1:0]   sh_q;
    logic             trig_q;
    logic [CHUNK-1:0] ck_q;
    logic [CW-1:0]    cnt_q;

    // Capture state
    logic [RECW-1:0]  mem_q [DEPTH];
    logic [AW-1:0]    rd_q;
    logic [AW-1:0]    wr_q;
    logic [AW:0]      lvl_q;
    logic [NUMW-1:0]  cyc_q;
    logic             pend_q;
    logic             lflag_q;
    logic [LOSTW-1:0] lost_q;

    logic             accept;
    logic             pop;
    logic             full;
    logic             push;
    logic             drop;
    logic             sel_cyc;
    logic             cyc_lost;
    logic             hdr_clear;
    logic [1:0]       nloss;
    logic [LOSTW:0]   lost_sum;
    logic [RECW-1:0]  head;
    logic [SHW-1:0]   sh_trig;
    logic [SHW-1:0]   sh_cyc;

    always_comb begin
        accept    = write_q && !fifo.busy;
        pop       = (state_q == StIdle) && (lvl_q != '0);
        full      = (lvl_q == (AW + 1)'(DEPTH));
        // A pop in the same clock frees the slot the push needs.
        push      = trigready && (!full || pop);
        drop      = trigready && full && !pop;
        sel_cyc   = (state_q == StIdle) && (lvl_q == '0) && pend_q;
        cyc_lost  = cycleready && pend_q && !sel_cyc;
        // Only a header that actually reported the loss may clear the flag.
        hdr_clear = (state_q == StHdr) && accept && !data_q[0];
        nloss     = {1'b0, drop} + {1'b0, cyc_lost};
        lost_sum  = {1'b0, lost_q} + (LOSTW + 1)'(nloss);
        head      = mem_q[rd_q];
        // Each field padded to whole chunks so the time field starts on a chunk boundary.
        sh_trig   = {PADM'(head[RECW-1:NUMW]), PADN'(head[NUMW-1:0])};
        sh_cyc    = SHW'(cyc_q);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= {timenum, trignum};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_q    <= '0;
            wr_q    <= '0;
            lvl_q   <= '0;
            cyc_q   <= '0;
            pend_q  <= 1'b0;
            lflag_q <= 1'b0;
            lost_q  <= '0;
        end else begin
            if (push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
            if (push && !pop) begin
                lvl_q <= lvl_q + 1'b1;
            end else if (pop && !push) begin
                lvl_q <= lvl_q - 1'b1;
            end
            if (cycleready) begin
                cyc_q  <= cyclenum;
                pend_q <= 1'b1;
            end else if (sel_cyc) begin
                pend_q <= 1'b0;
            end
            lflag_q <= (lflag_q && !hdr_clear) || drop || cyc_lost;
            lost_q  <= lost_sum[LOSTW] ? '1 : lost_sum[LOSTW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            data_q  <= '0;
            write_q <= 1'b0;
            sh_q    <= '0;
            trig_q  <= 1'b0;
            ck_q    <= '0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        sh_q    <= sh_trig;
                        trig_q  <= 1'b1;
                        data_q  <= lflag_q ? 8'hFE : 8'hFF;
                        write_q <= 1'b1;
                        state_q <= StHdr;
                    end else if (sel_cyc) begin
                        sh_q    <= sh_cyc;
                        trig_q  <= 1'b0;
                        data_q  <= lflag_q ? 8'hBE : 8'hBF;
                        write_q <= 1'b1;
                        state_q <= StHdr;
                    end
                end
                StHdr: begin
                    if (accept) begin
                        data_q  <= 8'(sh_q[CHUNK-1:0]);
                        ck_q    <= sh_q[CHUNK-1:0];
                        sh_q    <= sh_q >> CHUNK;
                        cnt_q   <= trig_q ? CW'(NCH_T - 1) : CW'(NCH_C - 1);
                        state_q <= StPay;
                    end
                end
                StPay: begin
                    if (accept) begin
                        if (cnt_q == '0) begin
                            if (CKSUM != 0) begin
                                data_q  <= 8'(ck_q);
                                state_q <= StCk;
                            end else begin
                                data_q  <= '0;
                                write_q <= 1'b0;
                                state_q <= StIdle;
                            end
                        end else begin
                            data_q <= 8'(sh_q[CHUNK-1:0]);
                            ck_q   <= ck_q ^ sh_q[CHUNK-1:0];
                            sh_q   <= sh_q >> CHUNK;
                            cnt_q  <= cnt_q - 1'b1;
                        end
                    end
                end
                StCk: begin
                    if (accept) begin
                        data_q  <= '0;
                        write_q <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign fifo.data  = data_q;
    assign fifo.write = write_q;
    assign lostcnt    = lost_q;
    assign qlevel     = lvl_q;
endmodule

// File: tb/tb_pushit_q.sv
// Bench for pushit_q: two instances (CHUNK=6 with checksum, CHUNK=7 without and a
// 2-bit lost counter) checked every clock against a byte-queue model of the packer.
module tb_pushit_q;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        trigready = 1'b0;
    logic        cycleready = 1'b0;
    logic        busy = 1'b0;
    logic [17:0] trignum = '0;
    logic [35:0] timenum = '0;
    logic [17:0] cyclenum = '0;
    logic [15:0] lost_a;
    logic [1:0]  lost_b;
    logic [2:0]  ql_a;
    logic [2:0]  ql_b;

    pushit_q_if if_a ();
    pushit_q_if if_b ();
    assign if_a.busy = busy;
    assign if_b.busy = busy;

    pushit_q #(.NUMW(18), .TIMEW(36), .CHUNK(6), .DEPTH(4), .CKSUM(1), .LOSTW(16)) u_dut_a (
        .clk(clk), .rstn(rstn), .trigready(trigready), .cycleready(cycleready),
        .trignum(trignum), .timenum(timenum), .cyclenum(cyclenum), .fifo(if_a),
        .lostcnt(lost_a), .qlevel(ql_a)
    );

    pushit_q #(.NUMW(18), .TIMEW(36), .CHUNK(7), .DEPTH(4), .CKSUM(0), .LOSTW(2)) u_dut_b (
        .clk(clk), .rstn(rstn), .trigready(trigready), .cycleready(cycleready),
        .trignum(trignum), .timenum(timenum), .cyclenum(cyclenum), .fifo(if_b),
        .lostcnt(lost_b), .qlevel(ql_b)
    );

    always #5 clk = ~clk;

    logic [7:0]  d_data [2];
    logic        d_wr   [2];
    int unsigned d_ql   [2];
    int unsigned d_lost [2];
    assign d_data[0] = if_a.data;
    assign d_data[1] = if_b.data;
    assign d_wr[0]   = if_a.write;
    assign d_wr[1]   = if_b.write;
    assign d_ql[0]   = 32'(ql_a);
    assign d_ql[1]   = 32'(ql_b);
    assign d_lost[0] = 32'(lost_a);
    assign d_lost[1] = 32'(lost_b);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Model: per instance, a record queue, a cycle slot, and the bytes still to send.
    int          cw   [2] = '{6, 7};
    bit          cks  [2] = '{1'b1, 1'b0};
    int unsigned lmax [2] = '{65535, 3};
    logic [53:0] mtq  [2][$];
    logic [7:0]  mout [2][$];
    bit          mpend [2];
    logic [17:0] mcyc  [2];
    bit          mflag [2];
    int unsigned mlost [2];

    task automatic build(input int k, input bit trig, input logic [17:0] num,
                         input logic [35:0] tim);
        logic [7:0] hdr;
        logic [6:0] m;
        logic [6:0] c;
        logic [6:0] x;
        hdr = trig ? 8'hFF : 8'hBF;
        if (mflag[k]) hdr[0] = 1'b0;
        mout[k].push_back(hdr);
        m = 7'((1 << cw[k]) - 1);
        x = '0;
        for (int i = 0; i < (18 + cw[k] - 1) / cw[k]; i++) begin
            c = 7'(num >> (i * cw[k])) & m;
            mout[k].push_back({1'b0, c});
            x ^= c;
        end
        if (trig) begin
            for (int i = 0; i < (36 + cw[k] - 1) / cw[k]; i++) begin
                c = 7'(tim >> (i * cw[k])) & m;
                mout[k].push_back({1'b0, c});
                x ^= c;
            end
        end
        if (cks[k]) mout[k].push_back({1'b0, x});
    endtask

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < 2; k++) begin
                mtq[k].delete();
                mout[k].delete();
                mpend[k] = 1'b0;
                mflag[k] = 1'b0;
                mlost[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                bit          lt;
                bit          lc;
                logic [7:0]  b;
                logic [53:0] r;
                lt = 1'b0;
                lc = 1'b0;
                if (mout[k].size() != 0) begin
                    if (!busy) begin
                        b = mout[k].pop_front();
                        if (b[7] && !b[0]) mflag[k] = 1'b0;
                    end
                end else if (mtq[k].size() != 0) begin
                    r = mtq[k].pop_front();
                    build(k, 1'b1, r[53:36], r[35:0]);
                end else if (mpend[k]) begin
                    mpend[k] = 1'b0;
                    build(k, 1'b0, mcyc[k], 36'd0);
                end
                if (trigready) begin
                    if (mtq[k].size() < DEPTH) mtq[k].push_back({trignum, timenum});
                    else lt = 1'b1;
                end
                if (cycleready) begin
                    lc = mpend[k];
                    mpend[k] = 1'b1;
                    mcyc[k] = cyclenum;
                end
                if (lt || lc) mflag[k] = 1'b1;
                mlost[k] = mlost[k] + lt + lc;
                if (mlost[k] > lmax[k]) mlost[k] = lmax[k];
            end
        end
    end

    // Per-clock comparison, plus a log of accepted bytes and write-high clocks.
    logic [7:0] acc  [2][$];
    int         wcnt [2];

    always @(negedge clk) begin
        if (rstn) begin
            for (int k = 0; k < 2; k++) begin
                bit ew;
                ew = (mout[k].size() != 0);
                chk($sformatf("write[%0d]", k), d_wr[k], ew);
                if (ew) chk($sformatf("data[%0d]", k), d_data[k], mout[k][0]);
                chk($sformatf("qlevel[%0d]", k), d_ql[k], mtq[k].size());
                chk($sformatf("lostcnt[%0d]", k), d_lost[k], mlost[k]);
                if (d_wr[k] && !busy) acc[k].push_back(d_data[k]);
                if (d_wr[k]) wcnt[k]++;
            end
        end
    end

    logic [7:0] exp_q [$];

    task automatic chk_bytes(input string name, input int k);
        chk({name, " length"}, acc[k].size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < acc[k].size(); i++)
            chk($sformatf("%s byte %0d", name, i), acc[k][i], exp_q[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit t, input bit c, input logic [17:0] n,
                         input logic [35:0] tm, input logic [17:0] cy);
        trignum    = n;
        timenum    = tm;
        cyclenum   = cy;
        trigready  = t;
        cycleready = c;
        tick();
        trigready  = 1'b0;
        cycleready = 1'b0;
    endtask

    task automatic wait_quiet(input string name);
        int q;
        int n;
        q = 0;
        n = 0;
        while (q < 3 && n < 2000) begin
            tick();
            n++;
            if (!if_a.write && !if_b.write && ql_a == 0 && ql_b == 0) q++;
            else q = 0;
        end
        chk({name, " drain timeout"}, q >= 3, 1'b1);
    endtask

    task automatic clear_logs();
        for (int k = 0; k < 2; k++) begin
            acc[k].delete();
            wcnt[k] = 0;
        end
    endtask

    task automatic set_trig_a();
        exp_q = '{8'hFF, 8'h0D, 8'h2F, 8'h2A, 8'h09, 8'h1E, 8'h16, 8'h11, 8'h23, 8'h04, 8'h3F};
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        clear_logs();
        repeat (3) tick();
        chk("reset write", if_a.write, 1'b0);
        chk("reset data", if_a.data, 8'h00);
        chk("reset qlevel", ql_a, 3'd0);
        chk("reset lostcnt", lost_a, 16'd0);
        rstn = 1'b1;
        tick();

        // Single trigger: latency, byte content for both chunk widths, write run length.
        clear_logs();
        pulse(1'b1, 1'b0, 18'h2ABCD, 36'h123456789, 18'h0);
        chk("latency capture write", if_a.write, 1'b0);
        tick();
        chk("latency header write", if_a.write, 1'b1);
        chk("latency header data", if_a.data, 8'hFF);
        wait_quiet("trig");
        set_trig_a();
        chk_bytes("trig A", 0);
        chk("trig A write clocks", wcnt[0], 11);
        exp_q = '{8'hFF, 8'h4D, 8'h57, 8'h0A, 8'h09, 8'h4F, 8'h15, 8'h1A, 8'h12, 8'h00};
        chk_bytes("trig B", 1);

        // Single cycle record.
        clear_logs();
        pulse(1'b0, 1'b1, 18'h0, 36'h0, 18'h00041);
        wait_quiet("cycle");
        exp_q = '{8'hBF, 8'h01, 8'h01, 8'h00, 8'h00};
        chk_bytes("cycle A", 0);
        exp_q = '{8'hBF, 8'h41, 8'h00, 8'h00};
        chk_bytes("cycle B", 1);

        // Trigger and cycle in the same clock: trigger record goes first.
        clear_logs();
        pulse(1'b1, 1'b1, 18'h2ABCD, 36'h123456789, 18'h00041);
        wait_quiet("both");
        chk("both A length", acc[0].size(), 16);
        chk("both A first header", acc[0][0], 8'hFF);
        chk("both A second header", acc[0][11], 8'hBF);
        chk("both B second header", acc[1][10], 8'hBF);

        // Back-pressure on the third payload byte.
        clear_logs();
        pulse(1'b1, 1'b0, 18'h2ABCD, 36'h123456789, 18'h0);
        n = 0;
        while (acc[0].size() < 3 && n < 50) begin
            tick();
            n++;
        end
        chk("stall reach timeout", n < 50, 1'b1);
        busy = 1'b1;
        repeat (5) begin
            tick();
            chk("stall held data", if_a.data, 8'h2A);
        end
        busy = 1'b0;
        wait_quiet("stall");
        set_trig_a();
        chk_bytes("stall A", 0);

        // Overflow: queue saturates, losses counted, next header flags the loss.
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        busy = 1'b1;
        for (int i = 0; i < 6; i++) pulse(1'b1, 1'b0, 18'(i + 1), 36'(i * 77), 18'h0);
        chk("overflow qlevel A", ql_a, 3'd4);
        chk("overflow lostcnt A", lost_a, 16'd1);
        chk("overflow lostcnt B", lost_b, 2'd1);
        clear_logs();
        busy = 1'b0;
        wait_quiet("overflow");
        chk("overflow A length", acc[0].size(), 55);
        chk("overflow A header 0", acc[0][0], 8'hFF);
        chk("overflow A header 1", acc[0][11], 8'hFE);
        chk("overflow A header 2", acc[0][22], 8'hFF);
        busy = 1'b1;
        for (int i = 0; i < 8; i++) pulse(1'b1, 1'b0, 18'(i), 36'(i), 18'h0);
        chk("saturate lostcnt A", lost_a, 16'd4);
        chk("saturate lostcnt B", lost_b, 2'd3);
        busy = 1'b0;
        wait_quiet("saturate");

        // Reset in the middle of a payload.
        clear_logs();
        for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0, 18'h155AA, 36'hABCDE1234, 18'h0);
        n = 0;
        while (acc[0].size() < 2 && n < 50) begin
            tick();
            n++;
        end
        chk("midreset pre qlevel", ql_a, 3'd2);
        rstn = 1'b0;
        #1;
        chk("midreset write A", if_a.write, 1'b0);
        chk("midreset write B", if_b.write, 1'b0);
        chk("midreset qlevel A", ql_a, 3'd0);
        #4;
        rstn = 1'b1;
        tick();
        clear_logs();
        pulse(1'b1, 1'b0, 18'h2ABCD, 36'h123456789, 18'h0);
        wait_quiet("after reset");
        set_trig_a();
        chk_bytes("after reset A", 0);

        // Random traffic with random back-pressure.
        for (int i = 0; i < 3000; i++) begin
            trignum    = 18'($urandom);
            timenum    = {4'($urandom), $urandom};
            cyclenum   = 18'($urandom);
            trigready  = ($urandom % 4) == 0;
            cycleready = ($urandom % 6) == 0;
            busy       = ($urandom % 3) == 0;
            tick();
        end
        trigready  = 1'b0;
        cycleready = 1'b0;
        busy       = 1'b0;
        wait_quiet("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
